twiddle_fetch_seq: RTL and testbench

//  Initiator side of the 32-entry complex twiddle ROM port: drives ADDR and captures DATA_RE/DATA_IM.
//  On START, walks every radix-2 FFT stage and butterfly index, presents the ROM address for each pair,
//  and streams (stage, index, twiddle) beats to the butterfly datapath over a valid/ready handshake.

---
 rtl/twiddle_fetch_seq_if.sv | 31 +++
 rtl/twiddle_fetch_seq.sv | 126 ++++++++++++
 tb/tb_twiddle_fetch_seq.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/twiddle_fetch_seq_if.sv
// Bundles the twiddle fetch control, ROM port and output beat stream.
// The master side is the fetch sequencer; the slave side is its environment.
interface twiddle_fetch_seq_if #(
    parameter int AW = 5,
    parameter int DW = 16,
    parameter int SW = 3
);
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_re;
    logic [DW-1:0] data_im;
    logic          tw_valid;
    logic          tw_ready;
    logic [DW-1:0] tw_re;
    logic [DW-1:0] tw_im;
    logic [SW-1:0] tw_stage;
    logic [AW-1:0] tw_idx;

    modport master (
        input  start, abort, data_re, data_im, tw_ready,
        output busy, done, addr, tw_valid, tw_re, tw_im, tw_stage, tw_idx
    );

    modport slave (
        output start, abort, data_re, data_im, tw_ready,
        input  busy, done, addr, tw_valid, tw_re, tw_im, tw_stage, tw_idx
    );
endinterface

// File: rtl/twiddle_fetch_seq.sv
// Walks every (stage, butterfly) pair of a radix-2 FFT, addresses the combinational
// twiddle ROM and streams captured (stage, index, twiddle) beats over valid/ready.
module twiddle_fetch_seq #(
    parameter int AW   = 5,
    parameter int DW   = 16,
    parameter int NSTG = 6,
    localparam int SW  = (NSTG > 1) ? $clog2(NSTG) : 1
) (
    input  logic               clk,
    input  logic               rst,
    twiddle_fetch_seq_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [AW-1:0] J_LAST   = {AW{1'b1}};
    localparam logic [SW-1:0] STG_LAST = SW'(NSTG - 1);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] stg_q, stg_d;
    logic [AW-1:0] j_q, j_d;
    logic          tw_valid_q, tw_valid_d;
    logic [DW-1:0] tw_re_q, tw_re_d;
    logic [DW-1:0] tw_im_q, tw_im_d;
    logic [SW-1:0] tw_stage_q, tw_stage_d;
    logic [AW-1:0] tw_idx_q, tw_idx_d;
    logic          done_q, done_d;
    logic          load;

    // Shifting within AW bits gives (j * 2**stg) mod DEPTH directly.
    assign bus.addr     = j_q << stg_q;
    assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done     = done_q;
    assign bus.tw_valid = tw_valid_q;
    assign bus.tw_re    = tw_re_q;
    assign bus.tw_im    = tw_im_q;
    assign bus.tw_stage = tw_stage_q;
    assign bus.tw_idx   = tw_idx_q;

    assign load = (state_q == ST_RUN) && (!tw_valid_q || bus.tw_ready);

    always_comb begin
        state_d    = state_q;
        stg_d      = stg_q;
        j_d        = j_q;
        tw_valid_d = tw_valid_q;
        tw_re_d    = tw_re_q;
        tw_im_d    = tw_im_q;
        tw_stage_d = tw_stage_q;
        tw_idx_d   = tw_idx_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    stg_d   = '0;
                    j_d     = '0;
                end
            end
            ST_RUN: begin
                if (load) begin
                    tw_re_d    = bus.data_re;
                    tw_im_d    = bus.data_im;
                    tw_stage_d = stg_q;
                    tw_idx_d   = j_q;
                    tw_valid_d = 1'b1;
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (stg_q == STG_LAST) begin
                            stg_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            stg_d = stg_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Only the final beat remains; its acceptance ends the run.
                if (tw_valid_q && bus.tw_ready) begin
                    tw_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort cancels any beat in flight but keeps the last captured data.
        if (bus.abort) begin
            state_d    = ST_IDLE;
            stg_d      = '0;
            j_d        = '0;
            tw_valid_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stg_q      <= '0;
            j_q        <= '0;
            tw_valid_q <= 1'b0;
            tw_re_q    <= '0;
            tw_im_q    <= '0;
            tw_stage_q <= '0;
            tw_idx_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stg_q      <= stg_d;
            j_q        <= j_d;
            tw_valid_q <= tw_valid_d;
            tw_re_q    <= tw_re_d;
            tw_im_q    <= tw_im_d;
            tw_stage_q <= tw_stage_d;
            tw_idx_q   <= tw_idx_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Scoreboard bench for twiddle_fetch_seq: a behavioural ROM feeds DATA_RE/IM and every
// accepted beat is matched against a reference model of (stage, j, ROM[j*2**stage mod 32]).
module tb_twiddle_fetch_seq;
    localparam int AW     = 5;
    localparam int DW     = 16;
    localparam int NSTG   = 6;
    localparam int SW     = 3;
    localparam int DEPTH  = 32;
    localparam int NBEATS = 192;

    typedef struct packed {
        logic [SW-1:0] stg;
        logic [AW-1:0] idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    twiddle_fetch_seq_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

    twiddle_fetch_seq #(.AW(AW), .DW(DW), .NSTG(NSTG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    function automatic logic [DW-1:0] rom_re(input logic [AW-1:0] a);
        return DW'(int'(a) * 1031 + 17);
    endfunction

    function automatic logic [DW-1:0] rom_im(input logic [AW-1:0] a);
        return DW'(61440 - int'(a) * 77);
    endfunction

    assign bus.data_re = rom_re(bus.addr);
    assign bus.data_im = rom_im(bus.addr);

    function automatic logic [AW-1:0] model_addr(input int n);
        int s;
        int j;
        s = n / DEPTH;
        j = n % DEPTH;
        return AW'((j * (1 << s)) % DEPTH);
    endfunction

    function automatic beat_t model_beat(input int n);
        beat_t b;
        logic [AW-1:0] a;
        a     = model_addr(n);
        b.stg = SW'(n / DEPTH);
        b.idx = AW'(n % DEPTH);
        b.re  = rom_re(a);
        b.im  = rom_im(a);
        return b;
    endfunction

    // Consumer-side record of every handshake completed at the following rising edge.
    always @(negedge clk) begin
        if (!rst && !bus.abort && bus.tw_valid && bus.tw_ready)
            obs_q.push_back({bus.tw_stage, bus.tw_idx, bus.tw_re, bus.tw_im});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int count);
        for (int n = 0; n < count; n++) exp_q.push_back(model_beat(n));
    endtask

    task automatic kick();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] snap;
        rst = 1'b1;
        step();
        step();
        snap = 64'({bus.busy, bus.done, bus.tw_valid, bus.addr, bus.tw_re, bus.tw_im, bus.tw_stage, bus.tw_idx});
        n_checks++;
        if (snap !== 64'd0) begin
            n_fails++;
            $display("FAIL reset_values: got %h, expected 0", snap);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            snap = 64'({bus.busy, bus.done, bus.tw_valid, bus.addr, bus.tw_re, bus.tw_im, bus.tw_stage, bus.tw_idx});
            n_checks++;
            if (snap !== 64'd0) begin
                n_fails++;
                $display("FAIL idle_hold cycle %0d: got %h, expected 0", c, snap);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_full_run();
        int done_cnt = 0;
        int done_at  = -1;
        beat_t e, o;
        push_expected(NBEATS);
        bus.tw_ready = 1'b1;
        kick();
        for (int k = 0; k <= 200; k++) begin
            if (k < NBEATS) begin
                n_checks++;
                if (bus.addr !== model_addr(k)) begin
                    n_fails++;
                    $display("FAIL addr_seq k=%0d: got %0d, expected %0d", k, bus.addr, model_addr(k));
                end
            end
            if (k == 73) begin
                n_checks++;
                if (bus.addr !== 5'd4) begin
                    n_fails++;
                    $display("FAIL addr_stg2_j9: got %0d, expected 4", bus.addr);
                end
            end
            if (k >= 1 && k <= NBEATS) begin
                n_checks++;
                if (bus.tw_valid !== 1'b1) begin
                    n_fails++;
                    $display("FAIL stream_gap k=%0d: tw_valid %b, expected 1", k, bus.tw_valid);
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = k;
                n_checks++;
                if (bus.tw_valid !== 1'b0) begin
                    n_fails++;
                    $display("FAIL done_with_valid k=%0d: tw_valid %b, expected 0", k, bus.tw_valid);
                end
            end
            step();
        end
        n_checks++;
        if (done_cnt !== 1 || done_at !== 193) begin
            n_fails++;
            $display("FAIL done_timing: got %0d pulses at edge %0d, expected 1 at edge 193", done_cnt, done_at);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fails++;
            $display("FAIL busy_after_run: got %b, expected 0", bus.busy);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL full_beat_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL full_beat: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        $display("test_full_run done");
    endtask

    task automatic test_backpressure();
        int stall_cnt = 0;
        bit saw_done  = 0;
        bit saw_j6    = 0;
        logic [63:0] snap, cur;
        beat_t e, o;
        push_expected(NBEATS);
        bus.tw_ready = 1'b1;
        kick();
        for (int k = 0; k < 400; k++) begin
            cur = 64'({bus.tw_stage, bus.tw_idx, bus.tw_re, bus.tw_im, bus.addr});
            if (bus.tw_valid && bus.tw_stage == 3'd1 && bus.tw_idx == 5'd5 && stall_cnt < 3) begin
                if (stall_cnt == 0) snap = cur;
                n_checks++;
                if (cur !== snap || bus.addr !== 5'd12) begin
                    n_fails++;
                    $display("FAIL stall_hold %0d: got %h addr %0d, expected %h addr 12", stall_cnt, cur, bus.addr, snap);
                end
                bus.tw_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus.tw_ready = 1'b1;
            end
            if (bus.tw_valid && bus.tw_stage == 3'd1 && bus.tw_idx == 5'd6 && !saw_j6) begin
                saw_j6 = 1;
                n_checks++;
                if (stall_cnt !== 3) begin
                    n_fails++;
                    $display("FAIL j6_after_stall: stalls seen %0d, expected 3", stall_cnt);
                end
            end
            if (bus.done === 1'b1) begin
                saw_done = 1;
                break;
            end
            step();
        end
        bus.tw_ready = 1'b1;
        n_checks++;
        if (!saw_done || !saw_j6) begin
            n_fails++;
            $display("FAIL bp_completion: done %0d j6 %0d, expected 1 1", saw_done, saw_j6);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL bp_beat_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL bp_beat: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        step();
        $display("test_backpressure done");
    endtask

    task automatic test_last_stall();
        bit   found = 0;
        beat_t e, o;
        push_expected(NBEATS);
        bus.tw_ready = 1'b1;
        kick();
        for (int k = 0; k < 300; k++) begin
            if (bus.tw_valid && bus.tw_stage == 3'd5 && bus.tw_idx == 5'd31) begin
                found = 1;
                break;
            end
            step();
        end
        bus.tw_ready = 1'b0;
        n_checks++;
        if (!found) begin
            n_fails++;
            $display("FAIL last_beat_seen: got 0, expected 1");
        end
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if ({bus.busy, bus.done, bus.tw_valid} !== 3'b101) begin
                n_fails++;
                $display("FAIL last_stall cycle %0d: busy/done/valid %b, expected 101", c, {bus.busy, bus.done, bus.tw_valid});
            end
        end
        bus.tw_ready = 1'b1;
        step();
        n_checks++;
        if ({bus.busy, bus.done, bus.tw_valid} !== 3'b010) begin
            n_fails++;
            $display("FAIL last_release: busy/done/valid %b, expected 010", {bus.busy, bus.done, bus.tw_valid});
        end
        step();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fails++;
            $display("FAIL done_one_cycle: got %b, expected 0", bus.done);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL ls_beat_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL ls_beat: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        $display("test_last_stall done");
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        bit found    = 0;
        beat_t e, o;
        push_expected(40);
        bus.tw_ready = 1'b1;
        kick();
        for (int k = 0; k < 100; k++) begin
            if (bus.tw_valid && bus.tw_stage == 3'd1 && bus.tw_idx == 5'd8) begin
                found = 1;
                break;
            end
            step();
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        n_checks++;
        if (!found || {bus.busy, bus.done, bus.tw_valid} !== 3'b000) begin
            n_fails++;
            $display("FAIL abort_idle: found %0d busy/done/valid %b, expected 1 000", found, {bus.busy, bus.done, bus.tw_valid});
        end
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fails++;
                $display("FAIL abort_no_done cycle %0d: got %b, expected 0", c, bus.done);
            end
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL abort_beat_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL abort_beat: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();

        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.tw_valid} !== 2'b00) begin
            n_fails++;
            $display("FAIL abort_start_idle: busy/valid %b, expected 00", {bus.busy, bus.tw_valid});
        end

        push_expected(NBEATS);
        kick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.addr !== 5'd0) begin
            n_fails++;
            $display("FAIL restart: busy %b addr %0d, expected 1 0", bus.busy, bus.addr);
        end
        for (int k = 0; k < 400; k++) begin
            bus.start = (k == 20 || k == 100) ? 1'b1 : 1'b0;
            if (bus.done === 1'b1) done_cnt++;
            if (done_cnt > 0 && k > 200) break;
            step();
        end
        bus.start = 1'b0;
        n_checks++;
        if (done_cnt !== 1) begin
            n_fails++;
            $display("FAIL restart_done: got %0d pulses, expected 1", done_cnt);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL restart_beat_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL restart_beat: got %h, expected %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        $display("test_abort done");
    endtask

    task automatic test_async_reset();
        logic [63:0] snap;
        bus.tw_ready = 1'b1;
        kick();
        for (int k = 0; k < 50; k++) step();
        #2;
        rst = 1'b1;
        #1;
        snap = 64'({bus.busy, bus.done, bus.tw_valid, bus.addr, bus.tw_re, bus.tw_im, bus.tw_stage, bus.tw_idx});
        n_checks++;
        if (snap !== 64'd0) begin
            n_fails++;
            $display("FAIL async_reset: got %h, expected 0", snap);
        end
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({bus.busy, bus.tw_valid} !== 2'b00) begin
            n_fails++;
            $display("FAIL post_reset_idle: busy/valid %b, expected 00", {bus.busy, bus.tw_valid});
        end
        exp_q.delete();
        obs_q.delete();
        $display("test_async_reset done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.tw_ready = 1'b0;
        #1;
        test_reset();
        test_full_run();
        test_backpressure();
        test_last_stall();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
